// File: rtl/alu_8bit.sv
// 8-bit ALU: combinational result/condition/carry plus an enable-gated result/flag
// register sampled by the control unit for branches and writeback.
module alu_8bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] sel,
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic [7:0] C,
   output logic       cmp,
   output logic       carry,
   output logic [7:0] C_q,
   output logic       cmp_q,
   output logic       zero_q,
   output logic       carry_q
);

   typedef enum logic [3:0] {
      OP_PASS = 4'b0000,
      OP_NOT  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_ADD  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SHL  = 4'b0111,
      OP_SHR  = 4'b1000,
      OP_SAR  = 4'b1001,
      OP_EQ   = 4'b1010,
      OP_NE   = 4'b1011,
      OP_LT   = 4'b1100,
      OP_LTU  = 4'b1101,
      OP_GE   = 4'b1110,
      OP_GEU  = 4'b1111
   } op_t;

   logic [8:0] sum;
   logic [8:0] diff;
   logic       big_shift;
   logic       lt_signed;
   logic       lt_unsigned;

   assign sum         = {1'b0, A} + {1'b0, B};
   assign diff        = {1'b0, A} - {1'b0, B};
   assign lt_unsigned = diff[8];
   assign lt_signed   = $signed(A) < $signed(B);
   // The full 8-bit amount counts: anything past 7 shifts every source bit out.
   assign big_shift   = (B > 8'd7);

   always_comb begin
      C     = 8'h00;
      cmp   = 1'b1;
      carry = 1'b0;
      case (op_t'(sel))
         OP_PASS: C = B;
         OP_NOT:  C = ~B;
         OP_AND:  C = A & B;
         OP_OR:   C = A | B;
         OP_XOR:  C = A ^ B;
         OP_ADD: begin
            C     = sum[7:0];
            carry = sum[8];
         end
         OP_SUB: begin
            C     = diff[7:0];
            carry = lt_unsigned;
         end
         OP_SHL:  C = big_shift ? 8'h00 : (A << B[2:0]);
         OP_SHR:  C = big_shift ? 8'h00 : (A >> B[2:0]);
         OP_SAR:  C = big_shift ? {8{A[7]}} : 8'($signed(A) >>> B[2:0]);
         OP_EQ:   cmp = (A == B);
         OP_NE:   cmp = (A != B);
         OP_LT:   cmp = lt_signed;
         OP_LTU:  cmp = lt_unsigned;
         OP_GE:   cmp = ~lt_signed;
         OP_GEU:  cmp = ~lt_unsigned;
         default: C = 8'h00;
      endcase
      if (sel >= 4'b1010)
         C = {7'b0, cmp};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         C_q     <= 8'h00;
         cmp_q   <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else if (en) begin
         C_q     <= C;
         cmp_q   <= cmp;
         zero_q  <= (C == 8'h00);
         carry_q <= carry;
      end
   end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: the driver queues hand-computed expectations,
// a monitor pops and compares them whenever the driver flags outputs as stable.
module tb_alu_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] sel;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] C;
   logic       cmp;
   logic       carry;
   logic [7:0] C_q;
   logic       cmp_q;
   logic       zero_q;
   logic       carry_q;

   alu_8bit dut (
      .clk(clk), .rst(rst), .en(en), .sel(sel), .A(A), .B(B),
      .C(C), .cmp(cmp), .carry(carry),
      .C_q(C_q), .cmp_q(cmp_q), .zero_q(zero_q), .carry_q(carry_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      bit         is_reg;
      logic [7:0] c;
      logic       cmp;
      logic       carry;
      logic       zero;
   } exp_t;

   exp_t exp_q[$];
   event check_ev;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input string field, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s: got %h, expected %h", nm, field, act, req);
      end
   endtask

   // Monitor: drain every queued expectation when outputs are presented.
   initial begin
      exp_t e;
      forever begin
         @(check_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_reg) begin
               chk(e.name, "C_q", C_q, e.c);
               chk(e.name, "cmp_q", {7'b0, cmp_q}, {7'b0, e.cmp});
               chk(e.name, "zero_q", {7'b0, zero_q}, {7'b0, e.zero});
               chk(e.name, "carry_q", {7'b0, carry_q}, {7'b0, e.carry});
               $display("reg  %-10s C_q=%h cmp_q=%b zero_q=%b carry_q=%b", e.name, C_q, cmp_q, zero_q, carry_q);
            end else begin
               chk(e.name, "C", C, e.c);
               chk(e.name, "cmp", {7'b0, cmp}, {7'b0, e.cmp});
               chk(e.name, "carry", {7'b0, carry}, {7'b0, e.carry});
               $display("comb %-10s sel=%b A=%h B=%h C=%h cmp=%b carry=%b", e.name, sel, A, B, C, cmp, carry);
            end
         end
      end
   end

   task automatic comb(input string nm, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic cm, input logic cy);
      exp_t e;
      sel = s; A = a; B = b;
      #1;
      e = '{name: nm, is_reg: 1'b0, c: c, cmp: cm, carry: cy, zero: 1'b0};
      exp_q.push_back(e);
      ->check_ev;
      #1;
   endtask

   task automatic regchk(input string nm, input logic [7:0] c, input logic cm, input logic z, input logic cy);
      exp_t e;
      e = '{name: nm, is_reg: 1'b1, c: c, cmp: cm, carry: cy, zero: z};
      exp_q.push_back(e);
      ->check_ev;
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; sel = 4'b0000; A = 8'h00; B = 8'h00;
      #2;
      regchk("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      comb("pass",   4'b0000, 8'h03, 8'h0C, 8'h0C, 1'b1, 1'b0);
      comb("not",    4'b0001, 8'h03, 8'h0C, 8'hF3, 1'b1, 1'b0);
      comb("and",    4'b0010, 8'hF3, 8'h25, 8'h21, 1'b1, 1'b0);
      comb("or",     4'b0011, 8'h73, 8'h8B, 8'hFB, 1'b1, 1'b0);
      comb("xor",    4'b0100, 8'hA3, 8'h45, 8'hE6, 1'b1, 1'b0);
      comb("shl",    4'b0111, 8'hA3, 8'h02, 8'h8C, 1'b1, 1'b0);
      comb("shr",    4'b1000, 8'hA3, 8'h02, 8'h28, 1'b1, 1'b0);
      comb("sar",    4'b1001, 8'hA3, 8'h02, 8'hE8, 1'b1, 1'b0);
      comb("sar9",   4'b1001, 8'hA3, 8'h09, 8'hFF, 1'b1, 1'b0);
      comb("sar200", 4'b1001, 8'h53, 8'hC8, 8'h00, 1'b1, 1'b0);
      comb("sar7",   4'b1001, 8'h80, 8'h07, 8'hFF, 1'b1, 1'b0);
      comb("shl8",   4'b0111, 8'hA3, 8'h08, 8'h00, 1'b1, 1'b0);
      comb("shl7",   4'b0111, 8'h01, 8'h07, 8'h80, 1'b1, 1'b0);
      comb("shr0",   4'b1000, 8'hA3, 8'h00, 8'hA3, 1'b1, 1'b0);
      comb("shr10",  4'b1000, 8'hFF, 8'h10, 8'h00, 1'b1, 1'b0);
      comb("add",    4'b0101, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b1);
      comb("add_nc", 4'b0101, 8'h12, 8'h34, 8'h46, 1'b1, 1'b0);
      comb("sub_b",  4'b0110, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b1);
      comb("sub",    4'b0110, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
      comb("lt",     4'b1100, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0);
      comb("ltu",    4'b1101, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0);
      comb("ge",     4'b1110, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0);
      comb("geu",    4'b1111, 8'h80, 8'h01, 8'h01, 1'b1, 1'b0);
      comb("ge_eq",  4'b1110, 8'h7F, 8'h7F, 8'h01, 1'b1, 1'b0);
      comb("eq",     4'b1010, 8'h5A, 8'h5A, 8'h01, 1'b1, 1'b0);
      comb("ne",     4'b1011, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);
      comb("ne_diff",4'b1011, 8'h5A, 8'h5B, 8'h01, 1'b1, 1'b0);

      // Register load, then hold with en low.
      @(negedge clk);
      en = 1'b1; sel = 4'b0110; A = 8'h33; B = 8'h33;
      @(posedge clk); #1;
      regchk("load_sub", 8'h00, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      en = 1'b0; sel = 4'b0101; A = 8'hF0; B = 8'h20;
      @(posedge clk); #1;
      regchk("hold", 8'h00, 1'b1, 1'b1, 1'b0);

      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      regchk("load_add", 8'h10, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset between edges; C keeps tracking inputs.
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      regchk("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
      comb("in_rst",  4'b0100, 8'hA3, 8'h45, 8'hE6, 1'b1, 1'b0);
      @(posedge clk); #1;
      regchk("rst_edge", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      @(posedge clk); #1;
      regchk("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      en = 1'b1; sel = 4'b1101; A = 8'h01; B = 8'h80;
      @(posedge clk); #1;
      regchk("load_ltu", 8'h01, 1'b1, 1'b0, 1'b0);

      begin
         bit drained = 1'b0;
         for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) begin
               drained = 1'b1;
               break;
            end
            #1;
         end
         if (!drained) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit combinational ALU for the 8-bit CPU datapath.
- Takes a 4-bit operation select and operands A and B; produces an 8-bit result C, a compare/condition bit cmp and a carry bit.
- Also provides a clocked result/flag register (C_q, cmp_q, zero_q, carry_q) that the control unit samples for branches and writeback.
- Combinational outputs settle within the same cycle; no internal pipeline.

Parameters:
- none (fixed 8-bit datapath, 4-bit select)

Ports:
- clk    input   1  system clock; all registered outputs update on rising edge
- rst    input   1  asynchronous, active-high reset; clears registered outputs
- en     input   1  load enable for result/flag register
- sel    input   4  operation select (encoding below)
- A      input   8  operand A (shift source for shifts)
- B      input   8  operand B (shift amount for shifts)
- C      output  8  combinational result
- cmp    output  1  combinational condition bit
- carry  output  1  combinational carry/borrow (ADD/SUB only, else 0)
- C_q    output  8  registered C
- cmp_q  output  1  registered cmp
- zero_q output  1  registered (C == 0)
- carry_q output 1  registered carry

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- C, cmp and carry are purely combinational from sel/A/B. They are independent of clk, rst and en, and valid within the same time step as an input change.
- Operation encoding:
  - 0000 PASS: C = B
  - 0001 NOT: C = ~B
  - 0010 AND: C = A & B
  - 0011 OR: C = A | B
  - 0100 XOR: C = A ^ B
  - 0101 ADD: C = A + B (mod 256); carry = bit 8 of the 9-bit sum
  - 0110 SUB: C = A - B (mod 256); carry = 1 when A < B unsigned (borrow)
  - 0111 SHL: C = A << B. B is taken as the full 8-bit unsigned amount; B >= 8 gives 0x00.
  - 1000 SHR logical: C = A >> B, zero fill; B >= 8 gives 0x00.
  - 1001 SAR arithmetic: C = A >>> B, fill with A[7]; B >= 8 gives 0x00 or 0xFF per A[7].
  - 1010 EQ: cmp = (A == B)
  - 1011 NE: cmp = (A != B)
  - 1100 LT signed: cmp = ($signed(A) < $signed(B))
  - 1101 LTU: cmp = (A < B) unsigned
  - 1110 GE signed: cmp = ($signed(A) >= $signed(B))
  - 1111 GEU: cmp = (A >= B) unsigned
- For sel 0000–1001, cmp = 1 (unconditional "true").
- For compare ops 1010–1111, C = {7'b0, cmp} and carry = 0.
- Shift of 0 returns A unchanged.
- Registered outputs:
  - rst = 1 (asynchronous): C_q = 0x00, cmp_q = 0, zero_q = 0, carry_q = 0, immediately and regardless of clk.
  - On rising clk with rst = 0 and en = 1: C_q <= C, cmp_q <= cmp, zero_q <= (C == 0), carry_q <= carry. One-cycle latency.
  - en = 0: all registered outputs hold.
  - rst asserted mid-operation overrides any load; the first load after release occurs on the first rising edge with en = 1.
- No X propagation from unused encodings: all 16 codes are defined.

Test Plan:
- Logic ops: sel=0000, A=0x03, B=0x0C -> C=0x0C, cmp=1. sel=0001 -> C=0xF3, cmp=1. sel=0010, A=0xF3, B=0x25 -> C=0x21. sel=0011, A=0x73, B=0x8B -> C=0xFB. sel=0100, A=0xA3, B=0x45 -> C=0xE6. cmp=1 in all cases.
- Shifts with A=0xA3, B=0x02: SHL (0111) -> C=0x8C; SHR (1000) -> C=0x28; SAR (1001) -> C=0xE8; cmp=1. SAR with B=0x09 -> C=0xFF; SHL with B=0x08 -> C=0x00.
- Arithmetic: ADD A=0xF0, B=0x20 -> C=0x10, carry=1. SUB A=0x05, B=0x07 -> C=0xFE, carry=1. SUB A=0x07, B=0x05 -> C=0x02, carry=0.
- Compares with A=0x80, B=0x01: LT (1100) -> cmp=1, C=0x01; LTU (1101) -> cmp=0, C=0x00; GE (1110) -> cmp=0; GEU (1111) -> cmp=1. EQ with A=B=0x5A -> cmp=1; NE -> cmp=0.
- Register: apply SUB A=B=0x33, en=1, one clk edge -> C_q=0x00, zero_q=1, cmp_q=1, carry_q=0. Then en=0 with new inputs -> registered outputs hold.
- Reset: assert rst between clock edges -> C_q/cmp_q/zero_q/carry_q go to 0 immediately. Combinational C still tracks the inputs during reset.
